// File: rtl/carregador_de_instrucoes.sv
// Instruction-memory loader: assembles a framed byte stream (N_hi, N_lo, 4*N payload, XOR checksum)
// into 32-bit words and writes them one per strobe, holding the CPU off while busy.
module carregador_de_instrucoes #(
    parameter int ENDERECO_INICIAL = 0,
    parameter int PROFUNDIDADE     = 26,
    parameter int LARGURA_END      = 26
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iniciar,
    input  logic [7:0]             byte_dado,
    input  logic                   byte_valido,
    output logic                   byte_pronto,
    output logic                   escrita_en,
    output logic [LARGURA_END-1:0] endereco_escrita,
    output logic [31:0]            dado_escrita,
    output logic                   ocupado,
    output logic                   carga_concluida,
    output logic                   erro_carga,
    output logic [2:0]             estado_depuracao
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONT_H    = 3'd1,
        CONT_L    = 3'd2,
        DADOS     = 3'd3,
        CHECKSUM  = 3'd4,
        CONCLUIDO = 3'd5,
        ERRO      = 3'd6
    } estado_t;

    localparam logic [15:0] PROF16 = 16'(PROFUNDIDADE);

    estado_t                r_estado;
    logic                   r_byte_pronto;
    logic                   r_escrita_en;
    logic [LARGURA_END-1:0] r_endereco;
    logic [31:0]            r_dado_escrita;
    logic                   r_ocupado;
    logic                   r_concluida;
    logic                   r_erro;
    logic [7:0]             r_n_alto;
    logic [15:0]            r_n;
    logic [15:0]            r_indice;
    logic [1:0]             r_cont_bytes;
    logic [23:0]            r_montagem;
    logic [7:0]             r_checksum;

    logic                   w_consumido;
    logic [15:0]            w_n;
    logic [31:0]            w_palavra;
    logic [15:0]            w_indice_prox;
    logic [LARGURA_END-1:0] w_endereco;

    // Handshake: a byte transfers on a rising edge where byte_valido && byte_pronto;
    // byte_pronto depends only on state, never on byte_valido.
    assign w_consumido   = byte_valido && r_byte_pronto;
    assign w_n           = {r_n_alto, byte_dado};
    // Only the first three bytes need storage; the fourth completes the word directly.
    assign w_palavra     = {r_montagem, byte_dado};
    assign w_indice_prox = r_indice + 16'd1;
    assign w_endereco    = LARGURA_END'(ENDERECO_INICIAL) + LARGURA_END'(r_indice);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado       <= OCIOSO;
            r_byte_pronto  <= 1'b0;
            r_escrita_en   <= 1'b0;
            r_endereco     <= '0;
            r_dado_escrita <= '0;
            r_ocupado      <= 1'b0;
            r_concluida    <= 1'b0;
            r_erro         <= 1'b0;
            r_n_alto       <= '0;
            r_n            <= '0;
            r_indice       <= '0;
            r_cont_bytes   <= '0;
            r_montagem     <= '0;
            r_checksum     <= '0;
        end else begin
            r_escrita_en <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_estado      <= CONT_H;
                        r_concluida   <= 1'b0;
                        r_erro        <= 1'b0;
                        r_ocupado     <= 1'b1;
                        r_byte_pronto <= 1'b1;
                        r_cont_bytes  <= '0;
                        r_indice      <= '0;
                        r_checksum    <= '0;
                    end
                end
                CONT_H: begin
                    if (w_consumido) begin
                        r_n_alto <= byte_dado;
                        r_estado <= CONT_L;
                    end
                end
                CONT_L: begin
                    if (w_consumido) begin
                        r_n <= w_n;
                        if (w_n > PROF16) begin
                            r_estado      <= ERRO;
                            r_erro        <= 1'b1;
                            r_ocupado     <= 1'b0;
                            r_byte_pronto <= 1'b0;
                        end else if (w_n == 16'd0) begin
                            r_estado <= CHECKSUM;
                        end else begin
                            r_estado <= DADOS;
                        end
                    end
                end
                DADOS: begin
                    if (w_consumido) begin
                        r_montagem   <= w_palavra[23:0];
                        r_checksum   <= r_checksum ^ byte_dado;
                        r_cont_bytes <= r_cont_bytes + 2'd1;
                        if (r_cont_bytes == 2'd3) begin
                            r_dado_escrita <= w_palavra;
                            r_endereco     <= w_endereco;
                            r_escrita_en   <= 1'b1;
                            r_indice       <= w_indice_prox;
                            // The strobe for the last word overlaps the first CHECKSUM cycle.
                            if (w_indice_prox == r_n) begin
                                r_estado <= CHECKSUM;
                            end
                        end
                    end
                end
                CHECKSUM: begin
                    if (w_consumido) begin
                        r_byte_pronto <= 1'b0;
                        r_ocupado     <= 1'b0;
                        if (byte_dado == r_checksum) begin
                            r_estado    <= CONCLUIDO;
                            r_concluida <= 1'b1;
                        end else begin
                            r_estado <= ERRO;
                            r_erro   <= 1'b1;
                        end
                    end
                end
                CONCLUIDO: r_estado <= OCIOSO;
                ERRO:      r_estado <= OCIOSO;
                default:   r_estado <= OCIOSO;
            endcase
        end
    end

    assign byte_pronto      = r_byte_pronto;
    assign escrita_en       = r_escrita_en;
    assign endereco_escrita = r_endereco;
    assign dado_escrita     = r_dado_escrita;
    assign ocupado          = r_ocupado;
    assign carga_concluida  = r_concluida;
    assign erro_carga       = r_erro;
    assign estado_depuracao = r_estado;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Bench for carregador_de_instrucoes: table of framed loads plus hand sequences for
// mid-load reset, ignored iniciar and bytes dropped while idle.
module tb_carregador_de_instrucoes;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iniciar;
    logic [7:0]  byte_dado;
    logic        byte_valido;
    logic        byte_pronto;
    logic        escrita_en;
    logic [25:0] endereco_escrita;
    logic [31:0] dado_escrita;
    logic        ocupado;
    logic        carga_concluida;
    logic        erro_carga;
    logic [2:0]  estado_depuracao;

    int n_comp = 0;
    int n_fail = 0;
    logic [57:0] exp_q[$];

    carregador_de_instrucoes dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .iniciar          (iniciar),
        .byte_dado        (byte_dado),
        .byte_valido      (byte_valido),
        .byte_pronto      (byte_pronto),
        .escrita_en       (escrita_en),
        .endereco_escrita (endereco_escrita),
        .dado_escrita     (dado_escrita),
        .ocupado          (ocupado),
        .carga_concluida  (carga_concluida),
        .erro_carga       (erro_carga),
        .estado_depuracao (estado_depuracao)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  chk;
        int          gap_max;
        bit          exp_ok;
    } vetor_t;

    vetor_t tab[9];

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_comp++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    always @(negedge clock) begin
        if (reset_n && escrita_en) begin
            if (exp_q.size() == 0) begin
                n_comp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         endereco_escrita, dado_escrita);
            end else begin
                logic [57:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(endereco_escrita), 64'(e[57:32]));
                check("write_data", 64'(dado_escrita), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int  gap;
        bit  got;
        bit  pronto_agora;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (gap > 0) begin
            byte_valido = 1'b0;
            repeat (gap) @(negedge clock);
        end
        byte_valido = 1'b1;
        byte_dado   = b;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            pronto_agora = byte_pronto;
            @(negedge clock);
            if (pronto_agora) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_comp++;
            n_fail++;
            $display("FAIL byte_timeout: got no byte_pronto expected accept of %0h", b);
        end
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int gap_max);
        logic [31:0] wv;
        wv = w;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({26'(idx), wv});
            send_byte(wv[31-8*b -: 8], gap_max);
        end
    endtask

    task automatic start_load();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("start_ocupado", 64'(ocupado), 64'(1));
        check("start_flags", 64'({carga_concluida, erro_carga}), 64'(0));
        check("start_pronto", 64'(byte_pronto), 64'(1));
    endtask

    task automatic end_check(input bit exp_ok);
        byte_valido = 1'b0;
        check("end_ocupado", 64'(ocupado), 64'(0));
        check("end_concluida", 64'(carga_concluida), 64'(exp_ok));
        check("end_erro", 64'(erro_carga), 64'(!exp_ok));
        check("end_pronto", 64'(byte_pronto), 64'(0));
        @(negedge clock);
        check("end_writes_drained", 64'(exp_q.size()), 64'(0));
        check("end_state_idle", 64'(estado_depuracao), 64'(0));
        check("end_flags_held", 64'({carga_concluida, erro_carga}), 64'({exp_ok, !exp_ok}));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string nome);
        check({nome, "_outs"}, 64'({byte_pronto, escrita_en, ocupado, carga_concluida, erro_carga}), 64'(0));
        check({nome, "_addr"}, 64'(endereco_escrita), 64'(0));
        check({nome, "_data"}, 64'(dado_escrita), 64'(0));
        check({nome, "_state"}, 64'(estado_depuracao), 64'(0));
    endtask

    initial begin
        logic [31:0] ws[3];

        tab[0] = '{n:16'd1,   w0:32'hDEADBEEF, w1:32'h0,        w2:32'h0,        chk:8'h22, gap_max:2, exp_ok:1'b1};
        tab[1] = '{n:16'd3,   w0:32'h01020304, w1:32'h11223344, w2:32'hA5A5A5A5, chk:8'h40, gap_max:0, exp_ok:1'b1};
        tab[2] = '{n:16'd1,   w0:32'h12345678, w1:32'h0,        w2:32'h0,        chk:8'h00, gap_max:1, exp_ok:1'b0};
        tab[3] = '{n:16'd27,  w0:32'h0,        w1:32'h0,        w2:32'h0,        chk:8'h00, gap_max:0, exp_ok:1'b0};
        tab[4] = '{n:16'd0,   w0:32'h0,        w1:32'h0,        w2:32'h0,        chk:8'h00, gap_max:1, exp_ok:1'b1};
        tab[5] = '{n:16'd2,   w0:32'hCAFEBABE, w1:32'h00000001, w2:32'h0,        chk:8'h31, gap_max:3, exp_ok:1'b1};
        tab[6] = '{n:16'd256, w0:32'h0,        w1:32'h0,        w2:32'h0,        chk:8'h00, gap_max:0, exp_ok:1'b0};
        tab[7] = '{n:16'd1,   w0:32'hFFFFFFFF, w1:32'h0,        w2:32'h0,        chk:8'h00, gap_max:0, exp_ok:1'b1};
        tab[8] = '{n:16'd0,   w0:32'h0,        w1:32'h0,        w2:32'h0,        chk:8'h01, gap_max:0, exp_ok:1'b0};

        reset_n     = 1'b0;
        iniciar     = 1'b0;
        byte_valido = 1'b0;
        byte_dado   = 8'h00;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        for (int t = 0; t < 9; t++) begin
            ws[0] = tab[t].w0;
            ws[1] = tab[t].w1;
            ws[2] = tab[t].w2;
            start_load();
            send_byte(tab[t].n[15:8], tab[t].gap_max);
            send_byte(tab[t].n[7:0], tab[t].gap_max);
            if (tab[t].n <= 16'd26) begin
                for (int i = 0; i < int'(tab[t].n); i++) send_word(i, ws[i], tab[t].gap_max);
                send_byte(tab[t].chk, tab[t].gap_max);
            end
            end_check(tab[t].exp_ok);
        end

        // Full-depth load: each word has four equal bytes, so the checksum is 00.
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'd26, 0);
        for (int i = 0; i < 26; i++) send_word(i, {4{8'(i + 1)}}, 0);
        send_byte(8'h00, 0);
        end_check(1'b1);

        // Reset after six payload bytes abandons the load.
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(0, 32'hAABBCCDD, 0);
        send_byte(8'hEE, 0);
        send_byte(8'hFF, 0);
        check("pre_reset_ocupado", 64'(ocupado), 64'(1));
        #1 reset_n = 1'b0;
        #1 check_all_zero("midload_reset");
        @(negedge clock);
        byte_valido = 1'b0;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clock);
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(0, 32'h0BADF00D, 0);
        send_byte(8'h5B, 0);
        end_check(1'b1);

        // Bytes in idle are dropped, including one coincident with iniciar; iniciar mid-load is ignored.
        byte_valido = 1'b1;
        byte_dado   = 8'h55;
        @(negedge clock);
        check("idle_byte_state", 64'(estado_depuracao), 64'(0));
        check("idle_byte_ocupado", 64'(ocupado), 64'(0));
        byte_dado = 8'h00;
        iniciar   = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("start_byte_dropped_state", 64'(estado_depuracao), 64'(1));
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(0, 32'hCAFEBABE, 0);
        byte_valido = 1'b0;
        iniciar     = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("midload_iniciar_state", 64'(estado_depuracao), 64'(3));
        check("midload_iniciar_ocupado", 64'(ocupado), 64'(1));
        send_word(1, 32'h00000001, 0);
        send_byte(8'h31, 0);
        end_check(1'b1);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule
